// File: rtl/axis_lab_pkg.sv
// Shared definitions for the AXI-Stream lab blocks: receiver state encoding,
// default widths and the power-sequence multiplier.
package axis_lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } rx_state_t;

  localparam int AXIS_DATA_SIZE   = 32;
  localparam int AXIS_COUNT_WIDTH = 16;
  localparam int POW_BASE         = 3;

endpackage

// File: rtl/pow3_expect.sv
// Expected-value tracker for the power-of-3 stream: holds the next expected
// word, flags a mismatch combinationally and advances/resyncs on each beat.
module pow3_expect
  import axis_lab_pkg::*;
#(
  parameter int DATA_SIZE   = AXIS_DATA_SIZE,
  parameter int EXPECT_INIT = 3
)(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_init,
  input  logic                 advance,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 mismatch
);

  localparam logic [DATA_SIZE-1:0] INIT_V = DATA_SIZE'(EXPECT_INIT);
  localparam logic [DATA_SIZE-1:0] MULT_V = DATA_SIZE'(POW_BASE);

  logic [DATA_SIZE-1:0] r_expect;

  assign mismatch = (data_in != r_expect);

  // On a match data_in equals r_expect, so data_in*3 covers both the normal
  // advance and the resync after a corrupted beat.
  always_ff @(posedge clk) begin
    if (!rstn || load_init) begin
      r_expect <= INIT_V;
    end else if (advance) begin
      r_expect <= data_in * MULT_V;
    end
  end

endmodule

// File: rtl/pow3_receiver.sv
// AXI4-Stream sink that checks the power-of-3 sequence and keeps status counters.
// Optional macro READY_THROTTLE_EN drops tready one cycle in every THROTTLE_PERIOD.
module pow3_receiver
  import axis_lab_pkg::*;
#(
  parameter int DATA_SIZE       = AXIS_DATA_SIZE,
  parameter int COUNT_WIDTH     = AXIS_COUNT_WIDTH,
  parameter int EXPECT_INIT     = 3,
  parameter int HALT_ON_ERROR   = 0,
  parameter int THROTTLE_PERIOD = 4
)(
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic                     s00_axis_enable,
  input  logic                     clear,
  input  logic [DATA_SIZE-1:0]     s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0]   s00_axis_tstrb,
  input  logic                     s00_axis_tvalid,
  input  logic                     s00_axis_tlast,
  output logic                     s00_axis_tready,
  output logic [COUNT_WIDTH-1:0]   beat_count,
  output logic [COUNT_WIDTH-1:0]   frame_count,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic                     error_flag,
  output logic [DATA_SIZE-1:0]     last_data,
  output logic [DATA_SIZE/8-1:0]   last_strb
);

  if ((DATA_SIZE % 8) != 0 || DATA_SIZE < 8) begin : g_bad_width
    $error("DATA_SIZE must be a non-zero multiple of 8");
  end
  if (THROTTLE_PERIOD < 1) begin : g_bad_period
    $error("THROTTLE_PERIOD must be at least 1");
  end

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  rx_state_t                r_state;
  rx_state_t                w_state_next;
  logic                     r_tready;
  logic                     w_thr_ok;
  logic                     w_mismatch;
  logic                     w_beat;
  logic [COUNT_WIDTH-1:0]   r_beat;
  logic [COUNT_WIDTH-1:0]   r_frame;
  logic [COUNT_WIDTH-1:0]   r_err;
  logic                     r_flag;
  logic [DATA_SIZE-1:0]     r_last_data;
  logic [DATA_SIZE/8-1:0]   r_last_strb;

  // tready is only ever high in RUN, so it alone qualifies a handshake; clear wins.
  assign w_beat = s00_axis_tvalid && r_tready && !clear;

  pow3_expect #(
    .DATA_SIZE   (DATA_SIZE),
    .EXPECT_INIT (EXPECT_INIT)
  ) u_expect (
    .clk       (s00_axis_aclk),
    .rstn      (s00_axis_aresetn),
    .load_init (clear),
    .advance   (w_beat),
    .data_in   (s00_axis_tdata),
    .mismatch  (w_mismatch)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (s00_axis_enable) w_state_next = RUN;
      RUN: begin
        if (HALT_ON_ERROR != 0 && w_beat && w_mismatch) w_state_next = HALT;
        else if (!s00_axis_enable)                      w_state_next = IDLE;
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = IDLE;
    endcase
    if (clear && r_state == HALT) w_state_next = IDLE;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) r_state <= IDLE;
    else                   r_state <= w_state_next;
  end

`ifdef READY_THROTTLE_EN
  localparam int TW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam logic [TW-1:0] THR_LAST = TW'(THROTTLE_PERIOD - 1);

  logic [TW-1:0] r_thr;
  logic [TW-1:0] w_thr_next;

  // Phase counter restarts whenever RUN is (re)entered; the last phase is the gap.
  always_comb begin
    w_thr_next = '0;
    if (w_state_next == RUN && r_state == RUN)
      w_thr_next = (r_thr == THR_LAST) ? '0 : r_thr + TW'(1);
  end

  assign w_thr_ok = (w_thr_next != THR_LAST);

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) r_thr <= '0;
    else                   r_thr <= w_thr_next;
  end
`else
  assign w_thr_ok = 1'b1;
`endif

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) r_tready <= 1'b0;
    else                   r_tready <= (w_state_next == RUN) && w_thr_ok;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn || clear) begin
      r_beat  <= '0;
      r_frame <= '0;
      r_err   <= '0;
      r_flag  <= 1'b0;
    end else if (w_beat) begin
      r_beat <= sat_inc(r_beat);
      if (s00_axis_tlast) r_frame <= sat_inc(r_frame);
      if (w_mismatch) begin
        r_err  <= sat_inc(r_err);
        r_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      r_last_data <= '0;
      r_last_strb <= '0;
    end else if (w_beat) begin
      r_last_data <= s00_axis_tdata;
      r_last_strb <= s00_axis_tstrb;
    end
  end

  assign s00_axis_tready = r_tready;
  assign beat_count      = r_beat;
  assign frame_count     = r_frame;
  assign error_count     = r_err;
  assign error_flag      = r_flag;
  assign last_data       = r_last_data;
  assign last_strb       = r_last_strb;

endmodule

// File: tb/tb_pow3_receiver.sv
// Scoreboard bench for pow3_receiver: a 32-bit non-halting instance and an
// 8-bit halting instance, both with 4-bit counters so saturation is reachable.
module tb_pow3_receiver;
  import axis_lab_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_en, a_clr, a_valid, a_last, a_ready, a_flag;
  logic [31:0] a_data, a_ldata;
  logic [3:0]  a_strb, a_lstrb, a_beat, a_frame, a_err;

  logic        b_rstn, b_en, b_clr, b_valid, b_last, b_ready, b_flag;
  logic [7:0]  b_data, b_ldata;
  logic [0:0]  b_strb, b_lstrb;
  logic [3:0]  b_beat, b_frame, b_err;

  pow3_receiver #(
    .DATA_SIZE(32), .COUNT_WIDTH(4), .EXPECT_INIT(3), .HALT_ON_ERROR(0), .THROTTLE_PERIOD(4)
  ) dut_a (
    .s00_axis_aclk(clk), .s00_axis_aresetn(a_rstn), .s00_axis_enable(a_en), .clear(a_clr),
    .s00_axis_tdata(a_data), .s00_axis_tstrb(a_strb), .s00_axis_tvalid(a_valid),
    .s00_axis_tlast(a_last), .s00_axis_tready(a_ready), .beat_count(a_beat),
    .frame_count(a_frame), .error_count(a_err), .error_flag(a_flag),
    .last_data(a_ldata), .last_strb(a_lstrb)
  );

  pow3_receiver #(
    .DATA_SIZE(8), .COUNT_WIDTH(4), .EXPECT_INIT(3), .HALT_ON_ERROR(1), .THROTTLE_PERIOD(4)
  ) dut_b (
    .s00_axis_aclk(clk), .s00_axis_aresetn(b_rstn), .s00_axis_enable(b_en), .clear(b_clr),
    .s00_axis_tdata(b_data), .s00_axis_tstrb(b_strb), .s00_axis_tvalid(b_valid),
    .s00_axis_tlast(b_last), .s00_axis_tready(b_ready), .beat_count(b_beat),
    .frame_count(b_frame), .error_count(b_err), .error_flag(b_flag),
    .last_data(b_ldata), .last_strb(b_lstrb)
  );

  typedef struct {
    int          beat;
    int          frame;
    int          err;
    bit          flag;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   a_sb   = 1'b1;
  logic a_pend = 1'b0;
  logic b_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitors: a handshake seen at a rising edge is scored at the next falling edge.
  always @(posedge clk) begin
    a_pend <= a_valid && a_ready && a_rstn && !a_clr && a_sb;
    b_pend <= b_valid && b_ready && b_rstn && !b_clr;
  end

  always @(negedge clk) begin
    if (a_pend) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_beat: actual beat_count %0d required no beat", a_beat);
      end else begin
        ea = q_a.pop_front();
        check("a_beat_count",  32'(a_beat),  32'(ea.beat));
        check("a_frame_count", 32'(a_frame), 32'(ea.frame));
        check("a_error_count", 32'(a_err),   32'(ea.err));
        check("a_error_flag",  32'(a_flag),  32'(ea.flag));
        check("a_last_data",   a_ldata,      ea.data);
      end
    end
    if (b_pend) begin
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_beat: actual beat_count %0d required no beat", b_beat);
      end else begin
        eb = q_b.pop_front();
        check("b_beat_count",  32'(b_beat),  32'(eb.beat));
        check("b_frame_count", 32'(b_frame), 32'(eb.frame));
        check("b_error_count", 32'(b_err),   32'(eb.err));
        check("b_error_flag",  32'(b_flag),  32'(eb.flag));
        check("b_last_data",   32'(b_ldata), eb.data);
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic l, input int xb, input int xf,
                        input int xe, input bit xfl);
    exp_t e;
    int   n;
    e.beat = xb; e.frame = xf; e.err = xe; e.flag = xfl; e.data = d;
    q_a.push_back(e);
    @(negedge clk);
    a_valid = 1'b1; a_data = d; a_last = l; a_strb = 4'hF;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    if (!a_ready) begin
      n_chk++; n_fail++;
      $display("FAIL a_ready_timeout: actual tready 0 required 1 within 20 cycles");
      void'(q_a.pop_back());
    end
  endtask

  task automatic send_b(input logic [7:0] d, input logic l, input int xb, input int xf,
                        input int xe, input bit xfl);
    exp_t e;
    int   n;
    e.beat = xb; e.frame = xf; e.err = xe; e.flag = xfl; e.data = 32'(d);
    q_b.push_back(e);
    @(negedge clk);
    b_valid = 1'b1; b_data = d; b_last = l; b_strb = 1'b1;
    n = 0;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    if (!b_ready) begin
      n_chk++; n_fail++;
      $display("FAIL b_ready_timeout: actual tready 0 required 1 within 20 cycles");
      void'(q_b.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rstn = 0; a_en = 0; a_clr = 0; a_valid = 0; a_last = 0; a_data = 0; a_strb = 0;
    b_rstn = 0; b_en = 0; b_clr = 0; b_valid = 0; b_last = 0; b_data = 0; b_strb = 0;
    repeat (3) @(negedge clk);
    check("a_reset_tready", 32'(a_ready), 0);
    check("a_reset_beat",   32'(a_beat),  0);
    check("a_reset_err",    32'(a_err),   0);
    check("a_reset_flag",   32'(a_flag),  0);
    check("a_reset_ldata",  a_ldata,      0);
    check("a_reset_lstrb",  32'(a_lstrb), 0);
    check("b_reset_tready", 32'(b_ready), 0);
    check("b_reset_state",  32'(dut_b.r_state), 32'(IDLE));
    a_rstn = 1; a_en = 1; b_rstn = 1; b_en = 1;
    @(negedge clk);
    @(negedge clk);
    check("a_enable_tready", 32'(a_ready), 1);

    // Clean stream, tlast on every beat
    send_a(3, 1, 1, 1, 0, 0);
    send_a(9, 1, 2, 2, 0, 0);
    send_a(27, 1, 3, 3, 0, 0);
    send_a(81, 1, 4, 4, 0, 0);
    send_a(243, 1, 5, 5, 0, 0);
    @(negedge clk); a_valid = 0;
    check("a_clean_beat",  32'(a_beat),  5);
    check("a_clean_frame", 32'(a_frame), 5);
    check("a_clean_err",   32'(a_err),   0);
    check("a_clean_ldata", a_ldata,      243);
    check("a_clean_lstrb", 32'(a_lstrb), 15);

    // Single corruption with resync
    a_clr = 1; @(negedge clk); a_clr = 0;
    check("a_clear_beat", 32'(a_beat), 0);
    check("a_clear_flag", 32'(a_flag), 0);
    send_a(3, 0, 1, 0, 0, 0);
    send_a(9, 0, 2, 0, 0, 0);
    send_a(28, 0, 3, 0, 1, 1);
    send_a(84, 0, 4, 0, 1, 1);
    send_a(252, 1, 5, 1, 1, 1);
    @(negedge clk); a_valid = 0;
    check("a_corrupt_err",  32'(a_err),  1);
    check("a_corrupt_flag", 32'(a_flag), 1);

    // tvalid while not ready is not a beat
    a_en = 0;
    @(negedge clk);
    check("a_disable_tready", 32'(a_ready), 0);
    a_valid = 1; a_data = 5;
    repeat (3) @(negedge clk);
    a_valid = 0;
    check("a_noaccept_beat",  32'(a_beat), 5);
    check("a_noaccept_ldata", a_ldata,     252);

    // Clear coinciding with a handshake
    a_en = 1;
    repeat (2) @(negedge clk);
    a_clr = 1; a_valid = 1; a_data = 99; a_last = 1;
    @(negedge clk);
    a_clr = 0; a_valid = 0; a_last = 0;
    check("a_clrbeat_beat",  32'(a_beat),  0);
    check("a_clrbeat_frame", 32'(a_frame), 0);
    check("a_clrbeat_err",   32'(a_err),   0);

    // Saturation: zeros (one error then all match), then ones (all mismatch)
    for (int i = 0; i < 18; i++)
      send_a(0, 0, (i + 1 > 15) ? 15 : i + 1, 0, 1, 1);
    for (int i = 0; i < 18; i++)
      send_a(1, 0, 15, 0, (i + 2 > 15) ? 15 : i + 2, 1);
    @(negedge clk); a_valid = 0;
    check("a_sat_beat", 32'(a_beat), 15);
    check("a_sat_err",  32'(a_err),  15);

    // Reset mid-stream with tvalid high
    a_rstn = 0; a_valid = 1; a_data = 7;
    @(negedge clk);
    check("a_midreset_tready", 32'(a_ready), 0);
    check("a_midreset_beat",   32'(a_beat),  0);
    check("a_midreset_err",    32'(a_err),   0);
    check("a_midreset_flag",   32'(a_flag),  0);
    check("a_midreset_ldata",  a_ldata,      0);
    a_rstn = 1; a_valid = 0;

`ifdef READY_THROTTLE_EN
    a_sb = 1'b0;
    repeat (3) @(negedge clk);
    a_valid = 1; a_data = 3;
    repeat (16) @(negedge clk);
    a_valid = 0;
    check("a_throttle_beat", 32'(a_beat), 12);
    a_sb = 1'b1;
`endif

    // 8-bit wrap: 729 mod 256 = 217
    send_b(3, 1, 1, 1, 0, 0);
    send_b(9, 1, 2, 2, 0, 0);
    send_b(27, 1, 3, 3, 0, 0);
    send_b(81, 1, 4, 4, 0, 0);
    send_b(243, 1, 5, 5, 0, 0);
    send_b(217, 1, 6, 6, 0, 0);
    @(negedge clk); b_valid = 0;
    check("b_wrap_err",   32'(b_err),   0);
    check("b_wrap_ldata", 32'(b_ldata), 217);

    // Halt on first mismatch
    b_clr = 1; @(negedge clk); b_clr = 0;
    send_b(3, 0, 1, 0, 0, 0);
    send_b(10, 0, 2, 0, 1, 1);
    @(negedge clk); b_data = 30;
    check("b_halt_state",  32'(dut_b.r_state), 32'(HALT));
    check("b_halt_tready", 32'(b_ready), 0);
    check("b_halt_beat",   32'(b_beat),  2);
    repeat (3) @(negedge clk);
    b_valid = 0;
    check("b_halt_hold_beat",  32'(b_beat),  0 + 2);
    check("b_halt_hold_state", 32'(dut_b.r_state), 32'(HALT));
    b_clr = 1; @(negedge clk); b_clr = 0;
    check("b_clear_state", 32'(dut_b.r_state), 32'(IDLE));
    check("b_clear_beat",  32'(b_beat), 0);
    check("b_clear_err",   32'(b_err),  0);
    check("b_clear_flag",  32'(b_flag), 0);

    repeat (2) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 0);
    check("b_queue_drained", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
